// File: rtl/fir_decim_buffer.sv
// ---------------------------------------------------------------------------
// fir_decim_buffer
//
// Downstream stage of the FIR filter. It keeps every DECIM-th valid input
// sample and queues the kept samples in a first-word-fall-through FIFO. The
// consumer reads them over a valid/ready handshake. A sticky flag records
// that a kept sample was lost because the FIFO was full.
//
// Parameters
//   DATA_W  sample width (two's complement, stored bit-exact)
//   DECIM   decimation factor, >= 1 (1 keeps every sample)
//   DEPTH   FIFO entries, power of two, >= 2
//   AW      log2(DEPTH)
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   in_data carries a new filtered sample this cycle
//   in_data    in   filtered sample from the FIR
//   out_valid  out  FIFO head holds a sample
//   out_data   out  FIFO head sample, 0 while empty
//   out_ready  in   consumer takes the head this cycle
//   level      out  current FIFO occupancy, 0..DEPTH
//   overflow   out  sticky: a kept sample was dropped on a full FIFO
//
// Handshake: a transfer happens on a rising edge where out_valid and
// out_ready are both 1. out_valid never depends on out_ready, and while
// out_valid=1 and out_ready=0 the head sample holds still. The input side
// has no ready: the producer cannot be stalled, so a kept sample that meets
// a full FIFO is dropped and overflow is raised instead.
// ---------------------------------------------------------------------------
module fir_decim_buffer #(
    parameter int DATA_W = 16,
    parameter int DECIM  = 2,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [AW:0]       level,
    output logic              overflow
);

    // Phase counter wide enough for 0..DECIM-1; one bit minimum for DECIM=1.
    localparam int            PW         = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
    localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [PW-1:0]     phase;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic full;
    logic keep;
    logic push;
    logic pop;

    // Fullness is judged on the registered level, so a pop in the same
    // cycle never makes room for the arriving sample.
    assign full = (level == FULL_LEVEL);
    assign keep = in_valid && (phase == '0);
    assign push = keep && !full;
    assign pop  = out_valid && out_ready;

    assign out_valid = (level != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            // Phase counts valid samples only, including dropped ones.
            if (in_valid) begin
                if (phase == PHASE_LAST) begin
                    phase <= '0;
                end else begin
                    phase <= phase + 1'b1;
                end
            end

            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (keep && full) begin
                overflow <= 1'b1;
            end

            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage is not reset; out_data is masked to 0 while empty, so stale
    // contents are never visible.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_fir_decim_buffer.sv
// ---------------------------------------------------------------------------
// tb_fir_decim_buffer
//
// Self-checking bench for fir_decim_buffer (DECIM=2, DEPTH=8).
//
// The reference model counts the valid samples since reset and keeps those
// whose index is a multiple of DECIM. Kept samples are held in a data queue
// together with an occupancy count. A separate monitor on the falling edge
// compares the DUT outputs with the model. It pops the expected queue
// whenever a handshake is about to complete.
// ---------------------------------------------------------------------------
module tb_fir_decim_buffer;

    localparam int DATA_W = 16;
    localparam int DECIM  = 2;
    localparam int DEPTH  = 8;
    localparam int AW     = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [AW:0]       level;
    logic              overflow;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard state.
    logic [DATA_W-1:0] exp_q[$];
    int                exp_level = 0;
    int                valid_cnt = 0;
    bit                exp_ovf   = 1'b0;
    bit                mon_en    = 1'b0;

    fir_decim_buffer #(
        .DATA_W(DATA_W),
        .DECIM (DECIM),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .level    (level),
        .overflow (overflow)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Evaluated on the rising edge. It uses only the tb-driven inputs and
    // its own state, which still reflects the start of the cycle.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_level = 0;
            valid_cnt = 0;
            exp_ovf   = 1'b0;
        end else begin
            bit was_full;
            bit kept;
            bit popped;
            was_full = (exp_level == DEPTH);
            popped   = out_ready && (exp_level != 0);
            kept     = in_valid && ((valid_cnt % DECIM) == 0);
            if (in_valid) valid_cnt++;
            if (kept && was_full) exp_ovf = 1'b1;
            if (kept && !was_full) begin
                exp_q.push_back(in_data);
                exp_level++;
            end
            if (popped) exp_level--;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            check("level", 32'(level), 32'(exp_level));
            check("out_valid", 32'(out_valid), 32'(exp_level != 0));
            check("overflow", 32'(overflow), 32'(exp_ovf));
            if (exp_level == 0) begin
                check("out_data_empty", 32'(out_data), 32'd0);
            end else if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL scoreboard_underrun: DUT head 0x%0h but no expected sample queued", out_data);
            end else if (out_ready && !rst) begin
                check("out_data_pop", 32'(out_data), 32'(exp_q.pop_front()));
            end else begin
                check("out_data_hold", 32'(out_data), 32'(exp_q[0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge and stay stable up to
    // the next rising edge.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    // Input is left toggling during reset; it must be ignored.
    task automatic do_reset(input int n);
        rst       = 1'b1;
        in_valid  = 1'($urandom_range(0, 1));
        in_data   = DATA_W'($urandom);
        out_ready = 1'($urandom_range(0, 1));
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        do_reset(3);
        mon_en = 1'b1;

        // T1: reset state
        check("t1_level", 32'(level), 32'd0);
        check("t1_out_valid", 32'(out_valid), 32'd0);
        check("t1_overflow", 32'(overflow), 32'd0);
        check("t1_out_data", 32'(out_data), 32'd0);

        // T2: 1..8 back to back, ready high -> 1,3,5,7 each one cycle later
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, DATA_W'(i), 1'b1);
            if (i % 2 == 1) check("t2_out_data", 32'(out_data), 32'(i));
            else            check("t2_gap_empty", 32'(out_valid), 32'd0);
        end
        repeat (3) step(1'b0, '0, 1'b1);

        // T3: gaps in in_valid do not advance the phase
        do_reset(1);
        step(1'b1, DATA_W'(10), 1'b1);
        check("t3_first", 32'(out_data), 32'd10);
        step(1'b0, DATA_W'($urandom), 1'b1);
        step(1'b1, DATA_W'(11), 1'b1);
        check("t3_skip", 32'(out_valid), 32'd0);
        step(1'b0, DATA_W'($urandom), 1'b1);
        step(1'b1, DATA_W'(12), 1'b1);
        check("t3_third", 32'(out_data), 32'd12);
        repeat (3) step(1'b0, '0, 1'b1);

        // T4: fill past full with ready low, then drain in order
        do_reset(1);
        for (int i = 0; i < 20; i++) step(1'b1, DATA_W'(100 + i), 1'b0);
        check("t4_level_full", 32'(level), 32'd8);
        check("t4_overflow", 32'(overflow), 32'd1);
        for (int k = 0; k < 8; k++) begin
            check("t4_drain", 32'(out_data), 32'(100 + 2 * k));
            step(1'b0, '0, 1'b1);
        end
        check("t4_empty", 32'(out_valid), 32'd0);
        check("t4_overflow_sticky", 32'(overflow), 32'd1);

        // T5: full FIFO, kept sample arrives together with a pop -> dropped
        do_reset(1);
        for (int i = 0; i < 16; i++) step(1'b1, DATA_W'(200 + i), 1'b0);
        check("t5_level_full", 32'(level), 32'd8);
        check("t5_no_overflow_yet", 32'(overflow), 32'd0);
        step(1'b1, DATA_W'(999), 1'b1);
        check("t5_level_after", 32'(level), 32'd7);
        check("t5_overflow", 32'(overflow), 32'd1);
        check("t5_head", 32'(out_data), 32'd202);
        repeat (8) step(1'b0, '0, 1'b1);

        // T6: reset with samples buffered
        do_reset(1);
        for (int i = 0; i < 10; i++) step(1'b1, DATA_W'(300 + i), 1'b0);
        check("t6_level5", 32'(level), 32'd5);
        do_reset(1);
        check("t6_level0", 32'(level), 32'd0);
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_overflow", 32'(overflow), 32'd0);
        step(1'b1, DATA_W'(777), 1'b0);
        check("t6_first_kept", 32'(out_data), 32'd777);
        check("t6_level1", 32'(level), 32'd1);

        // Random traffic: slow consumer first, then fast, with rare resets
        do_reset(1);
        for (int n = 0; n < 3000; n++) begin
            int thresh;
            thresh = (n < 1500) ? 3 : 8;
            if ($urandom_range(0, 199) == 0) begin
                do_reset(1);
            end else begin
                step(1'($urandom_range(0, 3) != 0), DATA_W'($urandom),
                     1'($urandom_range(0, 9) < thresh));
            end
        end
        repeat (12) step(1'b0, '0, 1'b1);
        check("final_drained", 32'(level), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
